// File: rtl/uart_checker_engine.sv
// Runtime-configurable UART transmit/receive engine with TX/RX FIFOs and sticky error flags.
// Optional feature: define UART_CHECKER_LOOPBACK_EN to add i_loopback (RX fed from o_tx).
module uart_checker_engine #(
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_BUFFER_ADDR_WIDTH = 4,
    parameter int G_DIV_WIDTH         = 16,
    parameter int G_FIRST_BIT         = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [G_DIV_WIDTH-1:0]       i_baud_div,
    input  logic [1:0]                   i_parity_mode,
    input  logic                         i_stop_bits,
    input  logic                         i_polarity,
    input  logic [G_DATA_WIDTH-1:0]      i_tx_data,
    input  logic                         i_tx_wr,
    output logic                         o_tx_full,
    output logic                         o_tx_busy,
    output logic                         o_tx,
    input  logic                         i_rx,
    output logic [G_DATA_WIDTH-1:0]      o_rx_data,
    input  logic                         i_rx_rd,
    output logic                         o_rx_empty,
    output logic [G_BUFFER_ADDR_WIDTH:0] o_rx_level,
    output logic                         o_parity_err,
    output logic                         o_frame_err,
    output logic                         o_overflow,
`ifdef UART_CHECKER_LOOPBACK_EN
    input  logic                         i_loopback,
`endif
    input  logic                         i_clr_err
);

    localparam int DW    = G_DATA_WIDTH;
    localparam int AW    = G_BUFFER_ADDR_WIDTH;
    localparam int DIVW  = G_DIV_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam int IDX_W = $clog2(DW + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] d);
        return (d < DIVW'(4)) ? DIVW'(4) : d;
    endfunction

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // Maps between user bit order and wire order (bit 0 is always the first bit on the line).
    function automatic logic [DW-1:0] wire_order(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i] = (G_FIRST_BIT != 0) ? d[DW-1-i] : d[i];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- TX FIFO
    logic [DW-1:0] tx_mem [DEPTH];
    logic [AW:0]   tx_wr_ptr_q, tx_rd_ptr_q;
    logic [AW:0]   tx_level;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    logic [DW-1:0] tx_head;

    assign tx_level = tx_wr_ptr_q - tx_rd_ptr_q;
    assign tx_full  = (tx_level == (AW+1)'(DEPTH));
    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_push  = i_tx_wr && !tx_full;
    assign tx_head  = tx_mem[tx_rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q[AW-1:0]] <= i_tx_data;
    end

    // ---------------------------------------------------------------- TX FSM
    state_t           tx_state_q, tx_state_d;
    logic [DIVW-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
    logic [DW-1:0]    tx_shift_q, tx_shift_d;
    logic [1:0]       tx_mode_q, tx_mode_d;
    logic             tx_two_stop_q, tx_two_stop_d;
    logic             tx_pol_q, tx_pol_d;
    logic             tx_par_q, tx_par_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_busy_q;
    logic             tx_bit_end, tx_load;

    assign tx_bit_end = (tx_cnt_q == tx_div_q - DIVW'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q + DIVW'(1);
        tx_div_d      = tx_div_q;
        tx_idx_d      = tx_idx_q;
        tx_shift_d    = tx_shift_q;
        tx_mode_d     = tx_mode_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_pol_d      = tx_pol_q;
        tx_par_d      = tx_par_q;
        tx_bit_d      = tx_bit_q;
        tx_pop        = 1'b0;
        tx_load       = 1'b0;

        unique case (tx_state_q)
            ST_IDLE: tx_load = 1'b1;
            ST_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = ST_DATA;
                    tx_bit_d   = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_W'(DW - 1)) begin
                        tx_idx_d = '0;
                        if (parity_on(tx_mode_q)) begin
                            tx_state_d = ST_PARITY;
                            tx_bit_d   = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            tx_bit_d   = 1'b1;
                        end
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = ST_STOP;
                    tx_bit_d   = 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == {{(IDX_W-1){1'b0}}, tx_two_stop_q}) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Shared by IDLE and the last stop cycle so queued frames follow with no idle gap.
        if (tx_load) begin
            tx_cnt_d = '0;
            tx_idx_d = '0;
            if (!tx_empty) begin
                tx_pop        = 1'b1;
                tx_state_d    = ST_START;
                tx_shift_d    = wire_order(tx_head);
                tx_par_d      = (^tx_head) ^ (i_parity_mode == 2'b10);
                tx_div_d      = clamp_div(i_baud_div);
                tx_mode_d     = i_parity_mode;
                tx_two_stop_d = i_stop_bits;
                tx_pol_d      = i_polarity;
                tx_bit_d      = 1'b0;
            end else begin
                tx_state_d = ST_IDLE;
                tx_bit_d   = 1'b1;
            end
        end

        tx_line_d = (tx_state_d == ST_IDLE) ? i_polarity : (tx_bit_d ? tx_pol_d : ~tx_pol_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= ST_IDLE;
            tx_cnt_q      <= '0;
            tx_div_q      <= DIVW'(4);
            tx_idx_q      <= '0;
            tx_shift_q    <= '0;
            tx_mode_q     <= 2'b00;
            tx_two_stop_q <= 1'b0;
            tx_pol_q      <= 1'b1;
            tx_par_q      <= 1'b0;
            tx_bit_q      <= 1'b1;
            tx_line_q     <= i_polarity;
            tx_busy_q     <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_div_q      <= tx_div_d;
            tx_idx_q      <= tx_idx_d;
            tx_shift_q    <= tx_shift_d;
            tx_mode_q     <= tx_mode_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_pol_q      <= tx_pol_d;
            tx_par_q      <= tx_par_d;
            tx_bit_q      <= tx_bit_d;
            tx_line_q     <= tx_line_d;
            tx_busy_q     <= (tx_state_q != ST_IDLE) || !tx_empty;
        end
    end

    assign o_tx      = tx_line_q;
    assign o_tx_full = tx_full;
    assign o_tx_busy = tx_busy_q;

    // ---------------------------------------------------------------- RX front end
    logic rx_src, rx_sync1_q, rx_sync2_q, rx_prev_q, rx_bit, rx_pol_sel;

`ifdef UART_CHECKER_LOOPBACK_EN
    assign rx_src = i_loopback ? tx_line_q : i_rx;
`else
    assign rx_src = i_rx;
`endif

    state_t rx_state_q, rx_state_d;
    logic   rx_pol_q, rx_pol_d;

    assign rx_pol_sel = (rx_state_q == ST_IDLE) ? i_polarity : rx_pol_q;
    assign rx_bit     = rx_pol_sel ? rx_sync2_q : ~rx_sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_q <= i_polarity;
            rx_sync2_q <= i_polarity;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rx_src;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_bit;
        end
    end

    // ---------------------------------------------------------------- RX FSM
    logic [DIVW-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
    logic [DW-1:0]    rx_shift_q, rx_shift_d;
    logic [1:0]       rx_mode_q, rx_mode_d;
    logic             rx_par_q, rx_par_d;
    logic             rx_push, perr_set, ferr_set;
    logic             rx_bit_end, rx_half_end;

    assign rx_bit_end  = (rx_cnt_q == rx_div_q - DIVW'(1));
    assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - DIVW'(1));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + DIVW'(1);
        rx_div_d   = rx_div_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_mode_d  = rx_mode_q;
        rx_pol_d   = rx_pol_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        perr_set   = 1'b0;
        ferr_set   = 1'b0;

        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_bit) begin
                    rx_state_d = ST_START;
                    rx_div_d   = clamp_div(i_baud_div);
                    rx_mode_d  = i_parity_mode;
                    rx_pol_d   = i_polarity;
                end
            end
            ST_START: begin
                // Mid-start check filters glitches shorter than half a bit.
                if (rx_half_end) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_par_d   = 1'b0;
                    rx_state_d = rx_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_bit, rx_shift_q[DW-1:1]};
                    rx_par_d   = rx_par_q ^ rx_bit;
                    if (rx_idx_q == IDX_W'(DW - 1)) begin
                        rx_state_d = parity_on(rx_mode_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    perr_set   = (rx_par_q ^ rx_bit) != (rx_mode_q == 2'b10);
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_push    = 1'b1;
                    ferr_set   = !rx_bit;
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIVW'(4);
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_mode_q  <= 2'b00;
            rx_pol_q   <= 1'b1;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_mode_q  <= rx_mode_d;
            rx_pol_q   <= rx_pol_d;
            rx_par_q   <= rx_par_d;
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW:0]   rx_wr_ptr_q, rx_rd_ptr_q;
    logic [AW:0]   rx_level;
    logic          rx_full, rx_empty, rx_pop, rx_wr, ovf_set;

    assign rx_level = rx_wr_ptr_q - rx_rd_ptr_q;
    assign rx_full  = (rx_level == (AW+1)'(DEPTH));
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_pop   = i_rx_rd && !rx_empty;
    // A pop in the same cycle frees the slot, so a push at full is accepted then.
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign ovf_set  = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
        end else begin
            if (rx_wr)  rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop) rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wr_ptr_q[AW-1:0]] <= wire_order(rx_shift_q);
    end

    assign o_rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr_q[AW-1:0]];
    assign o_rx_empty = rx_empty;
    assign o_rx_level = rx_level;

    // ---------------------------------------------------------------- sticky errors
    logic perr_q, ferr_q, ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            perr_q <= perr_set || (perr_q && !i_clr_err);
            ferr_q <= ferr_set || (ferr_q && !i_clr_err);
            ovf_q  <= ovf_set  || (ovf_q  && !i_clr_err);
        end
    end

    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_checker_engine.sv
// Self-checking bench for uart_checker_engine: TX line model, RX vector table, RX scoreboard.
module tb_uart_checker_engine;

    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int DIVW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DIVW-1:0] baud_div;
    logic [1:0]      parity_mode;
    logic            stop_bits, polarity;
    logic [DW-1:0]   tx_data;
    logic            tx_wr, tx_full, tx_busy, tx_line;
    logic            rx_line, rx_drv, loop_en;
    logic [DW-1:0]   rx_data;
    logic            rx_rd, rx_empty;
    logic [AW:0]     rx_level;
    logic            parity_err, frame_err, overflow, clr_err;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_checker_engine #(
        .G_DATA_WIDTH(DW),
        .G_BUFFER_ADDR_WIDTH(AW),
        .G_DIV_WIDTH(DIVW),
        .G_FIRST_BIT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_baud_div(baud_div),
        .i_parity_mode(parity_mode),
        .i_stop_bits(stop_bits),
        .i_polarity(polarity),
        .i_tx_data(tx_data),
        .i_tx_wr(tx_wr),
        .o_tx_full(tx_full),
        .o_tx_busy(tx_busy),
        .o_tx(tx_line),
        .i_rx(rx_line),
        .o_rx_data(rx_data),
        .i_rx_rd(rx_rd),
        .o_rx_empty(rx_empty),
        .o_rx_level(rx_level),
        .o_parity_err(parity_err),
        .o_frame_err(frame_err),
        .o_overflow(overflow),
        .i_clr_err(clr_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] sb_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    mode;
        logic          two_stop;
        logic          bad_par;
        logic          bad_stop;
        logic          clr_after;
        logic          exp_perr;
        logic          exp_ferr;
    } rx_vec_t;

    rx_vec_t rx_vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [DW-1:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        tick();
        tx_wr   = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Drives one frame on rx_drv (polarity 1), LSB first, followed by an idle gap.
    task automatic send_rx(input logic [DW-1:0] d, input int div, input logic [1:0] mode,
                           input logic two_stop, input logic bad_par, input logic bad_stop);
        rx_drv = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < DW; i++) begin
            rx_drv = d[i];
            repeat (div) tick();
        end
        if (mode == 2'b01 || mode == 2'b10) begin
            rx_drv = (^d) ^ (mode == 2'b10) ^ bad_par;
            repeat (div) tick();
        end
        rx_drv = ~bad_stop;
        repeat (div) tick();
        if (two_stop) begin
            rx_drv = 1'b1;
            repeat (div) tick();
        end
        rx_drv = 1'b1;
        repeat (2 * div) tick();
    endtask

    task automatic drain(input string tag);
        while (sb_q.size() > 0) begin
            logic [DW-1:0] exp_d;
            exp_d = sb_q.pop_front();
            check({tag, " not empty"}, 32'(rx_empty), 32'd0);
            check({tag, " data"}, 32'(rx_data), 32'(exp_d));
            rx_rd = 1'b1;
            tick();
            rx_rd = 1'b0;
        end
        check({tag, " empty after drain"}, 32'(rx_empty), 32'd1);
    endtask

    // Waits for a start bit, then checks every bit mid-way and the busy fall timing.
    task automatic check_tx_frame(input logic [DW-1:0] d, input int div, input logic [1:0] mode,
                                  input logic two_stop, input string tag);
        logic            exp_bits[$];
        int              k;
        int              guard;
        logic [DIVW-1:0] saved_div;
        logic [1:0]      saved_mode;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
        if (mode == 2'b01 || mode == 2'b10) exp_bits.push_back((^d) ^ (mode == 2'b10));
        exp_bits.push_back(1'b1);
        if (two_stop) exp_bits.push_back(1'b1);

        guard = 0;
        while (tx_line !== 1'b0 && guard < 400) begin
            tick();
            guard++;
        end
        check({tag, " start bit seen"}, 32'(tx_line), 32'd0);
        if (tx_line !== 1'b0) return;

        // Config changes mid-frame must not affect this frame.
        saved_div   = baud_div;
        saved_mode  = parity_mode;
        baud_div    = DIVW'(5);
        parity_mode = ~mode;

        k = 0;
        for (int j = 0; j < exp_bits.size(); j++) begin
            while (k < j * div + div / 2) begin
                tick();
                k++;
            end
            check($sformatf("%s bit %0d", tag, j), 32'(tx_line), 32'(exp_bits[j]));
        end
        while (k < exp_bits.size() * div) begin
            tick();
            k++;
        end
        check({tag, " busy at frame end"}, 32'(tx_busy), 32'd1);
        check({tag, " idle line after frame"}, 32'(tx_line), 32'd1);
        tick();
        check({tag, " busy fallen"}, 32'(tx_busy), 32'd0);
        baud_div    = saved_div;
        parity_mode = saved_mode;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_vecs[0] = '{data: 8'h55, mode: 2'b01, two_stop: 1'b0, bad_par: 1'b1, bad_stop: 1'b0,
                       clr_after: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b0};
        rx_vecs[1] = '{data: 8'h12, mode: 2'b01, two_stop: 1'b0, bad_par: 1'b0, bad_stop: 1'b1,
                       clr_after: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b1};
        rx_vecs[2] = '{data: 8'hC3, mode: 2'b10, two_stop: 1'b1, bad_par: 1'b0, bad_stop: 1'b0,
                       clr_after: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};
        rx_vecs[3] = '{data: 8'h0F, mode: 2'b11, two_stop: 1'b0, bad_par: 1'b0, bad_stop: 1'b0,
                       clr_after: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};

        rst         = 1'b1;
        baud_div    = DIVW'(10);
        parity_mode = 2'b01;
        stop_bits   = 1'b0;
        polarity    = 1'b1;
        tx_data     = '0;
        tx_wr       = 1'b0;
        rx_drv      = 1'b1;
        loop_en     = 1'b0;
        rx_rd       = 1'b0;
        clr_err     = 1'b0;
        repeat (3) tick();

        check("reset o_tx", 32'(tx_line), 32'd1);
        check("reset tx_full", 32'(tx_full), 32'd0);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset rx_empty", 32'(rx_empty), 32'd1);
        check("reset rx_level", 32'(rx_level), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset errors", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        rst = 1'b0;
        tick();

        // TX frame: div 10, even parity, one stop bit.
        push_tx(8'hA5);
        check_tx_frame(8'hA5, 10, 2'b01, 1'b0, "tx a5");

        // RX vector table.
        baud_div = DIVW'(8);
        for (int i = 0; i < 4; i++) begin
            parity_mode = rx_vecs[i].mode;
            stop_bits   = rx_vecs[i].two_stop;
            send_rx(rx_vecs[i].data, 8, rx_vecs[i].mode, rx_vecs[i].two_stop,
                    rx_vecs[i].bad_par, rx_vecs[i].bad_stop);
            sb_q.push_back(rx_vecs[i].data);
            check($sformatf("rx vec %0d level", i), 32'(rx_level), 32'(i + 1));
            check($sformatf("rx vec %0d parity_err", i), 32'(parity_err), 32'(rx_vecs[i].exp_perr));
            check($sformatf("rx vec %0d frame_err", i), 32'(frame_err), 32'(rx_vecs[i].exp_ferr));
            if (rx_vecs[i].clr_after) begin
                pulse_clr();
                check($sformatf("rx vec %0d flags cleared", i), {30'd0, parity_err, frame_err}, 32'd0);
            end
        end
        check("rx table no overflow", 32'(overflow), 32'd0);
        drain("rx table");

        // Loopback: div 4, odd parity, two stop bits.
        begin
            int guard;
            loop_en     = 1'b1;
            baud_div    = DIVW'(4);
            parity_mode = 2'b10;
            stop_bits   = 1'b1;
            push_tx(8'h00);
            push_tx(8'hFF);
            push_tx(8'h3C);
            sb_q.push_back(8'h00);
            sb_q.push_back(8'hFF);
            sb_q.push_back(8'h3C);
            guard = 0;
            while (tx_busy === 1'b1 && guard < 2000) begin
                tick();
                guard++;
            end
            check("loopback tx finished", 32'(tx_busy), 32'd0);
            repeat (5) tick();
            check("loopback rx level", 32'(rx_level), 32'd3);
            check("loopback errors", {29'd0, parity_err, frame_err, overflow}, 32'd0);
            drain("loopback");
            loop_en = 1'b0;
        end

        // Overflow on a depth-4 RX FIFO, then pop and push together at full.
        baud_div    = DIVW'(8);
        parity_mode = 2'b01;
        stop_bits   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [DW-1:0] d;
            d = DW'(8'h11 * (i + 1));
            send_rx(d, 8, 2'b01, 1'b0, 1'b0, 1'b0);
            if (i < 4) sb_q.push_back(d);
        end
        check("ovf level", 32'(rx_level), 32'd4);
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf head", 32'(rx_data), 32'(sb_q[0]));
        pulse_clr();
        check("ovf cleared", 32'(overflow), 32'd0);
        fork
            send_rx(8'h66, 8, 2'b01, 1'b0, 1'b0, 1'b0);
            begin
                repeat (86) tick();
                check("full pop head", 32'(rx_data), 32'(sb_q[0]));
                rx_rd = 1'b1;
                tick();
                rx_rd = 1'b0;
                void'(sb_q.pop_front());
            end
        join
        sb_q.push_back(8'h66);
        check("full pop+push level", 32'(rx_level), 32'd4);
        check("full pop+push no overflow", 32'(overflow), 32'd0);
        drain("overflow");

        // Glitch of div/4 on the RX line.
        rx_drv = 1'b0;
        repeat (2) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        check("glitch rx_empty", 32'(rx_empty), 32'd1);
        check("glitch rx_level", 32'(rx_level), 32'd0);
        check("glitch frame_err", 32'(frame_err), 32'd0);

        // Reset in the middle of a TX data bit.
        begin
            int guard;
            baud_div = DIVW'(10);
            push_tx(8'hA5);
            push_tx(8'h5A);
            guard = 0;
            while (tx_line !== 1'b0 && guard < 100) begin
                tick();
                guard++;
            end
            check("rst test start seen", 32'(tx_line), 32'd0);
            repeat (45) tick();
            check("rst test mid data bit3", 32'(tx_line), 32'd0);
            rst = 1'b1;
            tick();
            check("rst o_tx idle", 32'(tx_line), 32'd1);
            check("rst tx_busy", 32'(tx_busy), 32'd0);
            check("rst tx_full", 32'(tx_full), 32'd0);
            rst = 1'b0;
            repeat (20) tick();
            check("post-rst fifo empty (busy)", 32'(tx_busy), 32'd0);
            check("post-rst line idle", 32'(tx_line), 32'd1);
            push_tx(8'h3C);
            check_tx_frame(8'h3C, 10, 2'b01, 1'b0, "post-rst tx 3c");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
